// File: rtl/fifo_pkg.sv
// fifo_pkg: shared read-mode enum and count-width helper for the programmable FIFO
package fifo_pkg;

    typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// sync_fifo_prog_if: producer/consumer handshake, data and status bundle for the FIFO
interface sync_fifo_prog_if
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = cnt_width(FIFO_DEPTH);

    logic                  wr_en;
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] data_in;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  almostfull;
    logic                  almostempty;
    logic [CW-1:0]         count;

    modport master (
        output wr_en, rd_en, data_in,
        input  data_out, wr_ack, overflow, underflow,
        input  full, empty, almostfull, almostempty, count
    );

    modport slave (
        input  wr_en, rd_en, data_in,
        output data_out, wr_ack, overflow, underflow,
        output full, empty, almostfull, almostempty, count
    );
endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: unreset storage array, synchronous write port, asynchronous read address
module fifo_mem #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int PW         = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [PW-1:0]         wa,
    input  logic [FIFO_WIDTH-1:0] wd,
    input  logic [PW-1:0]         ra,
    output logic [FIFO_WIDTH-1:0] rd
);
    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    // store the accepted write word; contents are meaningless until written
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    assign rd = mem[ra];
endmodule

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: any-depth synchronous FIFO with programmable margins, count and FWFT option
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int         FIFO_WIDTH = 16,
    parameter int         FIFO_DEPTH = 8,
    parameter int         AF_MARGIN  = 1,
    parameter int         AE_MARGIN  = 1,
    parameter fifo_mode_e MODE       = FIFO_STD
) (
    input logic             clk,
    input logic             rst_n,
    sync_fifo_prog_if.slave bus
);
    localparam int CW = cnt_width(FIFO_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [FIFO_WIDTH-1:0] dout_q, dout_d, rd_data;
    logic                  wr_ack_q, wr_ack_d, overflow_q, overflow_d, underflow_q, underflow_d;
    logic                  full, empty, rd_acc, wr_acc;

    assign full   = count_q == CW'(FIFO_DEPTH);
    assign empty  = count_q == '0;
    assign rd_acc = bus.rd_en && !empty;
    assign wr_acc = bus.wr_en && (!full || rd_acc);

    fifo_mem #(.FIFO_WIDTH(FIFO_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .PW(PW)) u_mem (
        .clk (clk),
        .we  (wr_acc),
        .wa  (wr_ptr_q),
        .wd  (bus.data_in),
        .ra  (rd_ptr_q),
        .rd  (rd_data)
    );

    // next-state: explicit pointer wrap at FIFO_DEPTH-1 so any depth works
    always_comb begin
        wr_ptr_d    = wr_acc ? ((wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d    = rd_acc ? ((rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        count_d     = (wr_acc && !rd_acc) ? count_q + 1'b1 : (rd_acc && !wr_acc) ? count_q - 1'b1 : count_q;
        dout_d      = rd_acc ? rd_data : dout_q;
        wr_ack_d    = wr_acc;
        overflow_d  = bus.wr_en && !wr_acc;
        underflow_d = bus.rd_en && empty;
    end

    // state registers; async clear empties the FIFO and zeroes every status output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.data_out    = (MODE == FIFO_FWFT) ? (empty ? '0 : rd_data) : dout_q;
    assign bus.wr_ack      = wr_ack_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.count       = count_q;
    assign bus.almostfull  = (count_q >= CW'(FIFO_DEPTH - AF_MARGIN)) && !full;
    assign bus.almostempty = (count_q <= CW'(AE_MARGIN)) && !empty;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog: directed scoreboard bench over STD depth-8, STD depth-5 and FWFT depth-8 instances
module tb_sync_fifo_prog;
    import fifo_pkg::*;

    logic clk;
    logic rst_n;
    int   passes = 0;
    int   total  = 0;
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] qc[$];
    logic [15:0] exp_w;

    sync_fifo_prog_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) ifa ();
    sync_fifo_prog_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) ifb ();
    sync_fifo_prog_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) ifc ();

    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_MARGIN(1), .AE_MARGIN(1), .MODE(FIFO_STD))
        ua (.clk(clk), .rst_n(rst_n), .bus(ifa));
    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_MARGIN(2), .AE_MARGIN(2), .MODE(FIFO_STD))
        ub (.clk(clk), .rst_n(rst_n), .bus(ifb));
    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_MARGIN(1), .AE_MARGIN(1), .MODE(FIFO_FWFT))
        uc (.clk(clk), .rst_n(rst_n), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        ifa.wr_en = 0; ifa.rd_en = 0; ifa.data_in = '0;
        ifb.wr_en = 0; ifb.rd_en = 0; ifb.data_in = '0;
        ifc.wr_en = 0; ifc.rd_en = 0; ifc.data_in = '0;
        cyc(); cyc();
        chk("rst_empty", ifa.empty, 1);
        chk("rst_full", ifa.full, 0);
        chk("rst_af", ifa.almostfull, 0);
        chk("rst_ae", ifa.almostempty, 0);
        chk("rst_flags_st", {ifa.wr_ack, ifa.overflow, ifa.underflow}, 0);
        chk("rst_dout", ifa.data_out, 0);
        chk("rst_count", ifa.count, 0);
        chk("rst_dout_fwft", ifc.data_out, 0);
        rst_n = 1'b1;
        cyc();
        // read from empty after reset
        ifa.rd_en = 1;
        cyc();
        chk("udf_pulse", ifa.underflow, 1);
        chk("udf_empty", ifa.empty, 1);
        chk("udf_count", ifa.count, 0);
        chk("udf_dout", ifa.data_out, 0);
        ifa.rd_en = 0;
        cyc();
        chk("udf_clear", ifa.underflow, 0);
        chk("udf_dout2", ifa.data_out, 0);
        // fill and overflow
        for (int i = 1; i <= 8; i++) begin
            ifa.wr_en = 1; ifa.data_in = 16'(i); qa.push_back(16'(i));
            cyc();
            chk("fill_count", ifa.count, i);
            chk("fill_ack", ifa.wr_ack, 1);
            chk("fill_af", ifa.almostfull, i == 7);
            chk("fill_full", ifa.full, i == 8);
        end
        ifa.data_in = 16'h0009;
        cyc();
        chk("ovf_pulse", ifa.overflow, 1);
        chk("ovf_ack", ifa.wr_ack, 0);
        chk("ovf_count", ifa.count, 8);
        // simultaneous read and write while full
        ifa.data_in = 16'h00AA; ifa.rd_en = 1; qa.push_back(16'h00AA);
        cyc();
        exp_w = qa.pop_front();
        chk("both_full_dout", ifa.data_out, exp_w);
        chk("both_full_count", ifa.count, 8);
        chk("both_full_ack", ifa.wr_ack, 1);
        chk("both_full_ovf", ifa.overflow, 0);
        // drain across pointer wrap; empty must rise on the last read edge
        ifa.wr_en = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            exp_w = qa.pop_front();
            chk("drain_dout", ifa.data_out, exp_w);
            chk("drain_empty", ifa.empty, k == 7);
            chk("drain_count", ifa.count, 7 - k);
        end
        ifa.rd_en = 0; ifa.wr_en = 1; ifa.data_in = 16'h0055; qa.push_back(16'h0055);
        cyc();
        chk("post_drain_ack", ifa.wr_ack, 1);
        chk("post_drain_count", ifa.count, 1);
        ifa.wr_en = 0; ifa.rd_en = 1;
        cyc();
        exp_w = qa.pop_front();
        chk("post_drain_dout", ifa.data_out, exp_w);
        chk("std_hold_udf", ifa.empty, 1);
        ifa.rd_en = 1;
        cyc();
        chk("std_udf_hold_dout", ifa.data_out, exp_w);
        ifa.rd_en = 0;
        // depth 5, margins 2: fill to 4 then 12 paired operations across wrap
        for (int i = 1; i <= 4; i++) begin
            ifb.wr_en = 1; ifb.data_in = 16'h0100 + 16'(i); qb.push_back(16'h0100 + 16'(i));
            cyc();
            chk("b_fill_count", ifb.count, i);
            chk("b_fill_ae", ifb.almostempty, i <= 2);
            chk("b_fill_af", ifb.almostfull, i >= 3);
        end
        ifb.rd_en = 1;
        for (int n = 0; n < 12; n++) begin
            ifb.data_in = 16'h0200 + 16'(n); qb.push_back(16'h0200 + 16'(n));
            cyc();
            exp_w = qb.pop_front();
            chk("b_pair_dout", ifb.data_out, exp_w);
            chk("b_pair_count", ifb.count, 4);
        end
        ifb.rd_en = 0; ifb.data_in = 16'h0300; qb.push_back(16'h0300);
        cyc();
        chk("b_full", ifb.full, 1);
        chk("b_full_af", ifb.almostfull, 0);
        ifb.wr_en = 0; ifb.rd_en = 1;
        for (int k = 4; k >= 0; k--) begin
            cyc();
            exp_w = qb.pop_front();
            chk("b_drain_dout", ifb.data_out, exp_w);
            chk("b_drain_count", ifb.count, k);
            chk("b_drain_ae", ifb.almostempty, k >= 1 && k <= 2);
            chk("b_drain_af", ifb.almostfull, k >= 3);
            chk("b_drain_empty", ifb.empty, k == 0);
        end
        ifb.rd_en = 0;
        // FWFT: head visible without a read, zero when empty
        ifc.wr_en = 1; ifc.data_in = 16'h1234; qc.push_back(16'h1234);
        cyc();
        ifc.wr_en = 0;
        chk("fwft_head", ifc.data_out, qc[0]);
        chk("fwft_count", ifc.count, 1);
        cyc();
        chk("fwft_head_hold", ifc.data_out, qc[0]);
        ifc.rd_en = 1; void'(qc.pop_front());
        cyc();
        chk("fwft_empty", ifc.empty, 1);
        chk("fwft_zero", ifc.data_out, 0);
        ifc.wr_en = 1; ifc.data_in = 16'h5678; qc.push_back(16'h5678);
        cyc();
        chk("fwft_both_udf", ifc.underflow, 1);
        chk("fwft_both_count", ifc.count, 1);
        chk("fwft_both_ack", ifc.wr_ack, 1);
        chk("fwft_both_head", ifc.data_out, qc[0]);
        ifc.rd_en = 0; ifc.data_in = 16'h9ABC; qc.push_back(16'h9ABC);
        cyc();
        ifc.wr_en = 0;
        chk("fwft_two_head", ifc.data_out, qc[0]);
        ifc.rd_en = 1; void'(qc.pop_front());
        cyc();
        chk("fwft_next_head", ifc.data_out, qc[0]);
        void'(qc.pop_front());
        cyc();
        ifc.rd_en = 0;
        chk("fwft_final_empty", ifc.empty, 1);
        chk("fwft_final_zero", ifc.data_out, 0);
        // async reset mid-stream with count 5
        ifa.wr_en = 1;
        for (int i = 0; i < 5; i++) begin
            ifa.data_in = 16'h0A00 + 16'(i);
            cyc();
        end
        ifa.wr_en = 0;
        chk("mid_count", ifa.count, 5);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_count", ifa.count, 0);
        chk("arst_empty", ifa.empty, 1);
        chk("arst_flags", {ifa.full, ifa.almostfull, ifa.almostempty}, 0);
        chk("arst_status", {ifa.wr_ack, ifa.overflow, ifa.underflow}, 0);
        chk("arst_dout", ifa.data_out, 0);
        qa.delete();
        cyc();
        rst_n = 1'b1;
        cyc();
        ifa.rd_en = 1;
        cyc();
        ifa.rd_en = 0;
        chk("arst_first_udf", ifa.underflow, 1);
        chk("arst_first_count", ifa.count, 0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
